// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, opcode classes,
// opcode constants and datapath select codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsJal,
        ClsJalr, ClsLui, ClsAuipc, ClsFence, ClsSystem
    } cls_e;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcMisc   = 7'b0001111;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [1:0] PcPlus4  = 2'd0;
    localparam logic [1:0] PcBranch = 2'd1;
    localparam logic [1:0] PcJalr   = 2'd2;

    localparam logic [1:0] WbAlu  = 2'd0;
    localparam logic [1:0] WbLoad = 2'd1;
    localparam logic [1:0] WbPc4  = 2'd2;
    localparam logic [1:0] WbImmU = 2'd3;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmU = 3'd3;
    localparam logic [2:0] ImmJ = 3'd4;

    localparam logic [1:0] AluAdd   = 2'd0;
    localparam logic [1:0] AluFunct = 2'd1;
    localparam logic [1:0] AluCmp   = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Combinational opcode classifier: flags legal RV32I base opcodes and maps them to a class.
module multicycle_ctrl_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       legal_o,
    output cls_e       cls_o
);

    always_comb begin
        legal_o = 1'b1;
        cls_o   = ClsAlu;
        case (opcode_i)
            OpcOp, OpcOpImm: cls_o = ClsAlu;
            OpcLoad:         cls_o = ClsLoad;
            OpcStore:        cls_o = ClsStore;
            OpcBranch:       cls_o = ClsBranch;
            OpcJal:          cls_o = ClsJal;
            OpcJalr:         cls_o = ClsJalr;
            OpcLui:          cls_o = ClsLui;
            OpcAuipc:        cls_o = ClsAuipc;
            OpcMisc:         cls_o = ClsFence;
            OpcSystem:       cls_o = ClsSystem;
            default:         legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, datapath selects,
// memory handshakes, trap handling and retired-instruction counting.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic [2:0]       imm_sel,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halt,
    output logic             illegal
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("multicycle_ctrl only supports XLEN = 32");
    end

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             legal;
    cls_e             cls;

    multicycle_ctrl_dec u_dec (
        .opcode_i (opcode),
        .legal_o  (legal),
        .cls_o    (cls)
    );

    // ALU/immediate selects stay stable from EXEC through WB so the ALU result is still valid
    // when it is written back (no ALU output register in the datapath).
    always_comb begin
        alu_op    = AluAdd;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        imm_sel   = ImmI;
        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            case (cls)
                ClsAlu: begin
                    alu_op    = AluFunct;
                    alu_b_sel = ~opcode[5];
                end
                ClsLoad:   alu_b_sel = 1'b1;
                ClsStore: begin
                    alu_b_sel = 1'b1;
                    imm_sel   = ImmS;
                end
                ClsBranch: begin
                    alu_op  = AluCmp;
                    imm_sel = ImmB;
                end
                ClsJal:    imm_sel = ImmJ;
                ClsLui:    imm_sel = ImmU;
                ClsAuipc: begin
                    alu_a_sel = 1'b1;
                    alu_b_sel = 1'b1;
                    imm_sel   = ImmU;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PcPlus4;
        rf_we     = 1'b0;
        wb_sel    = WbAlu;
        retire    = 1'b0;
        case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (legal) begin
                    state_d = StExec;
                end else begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end
            end
            StExec: begin
                case (cls)
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch: begin
                        if (funct3 == 3'b010 || funct3 == 3'b011) begin
                            state_d   = StTrap;
                            illegal_d = 1'b1;
                        end else begin
                            pc_we   = 1'b1;
                            pc_sel  = branch_taken ? PcBranch : PcPlus4;
                            retire  = 1'b1;
                            state_d = StFetch;
                        end
                    end
                    ClsFence: begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    ClsSystem: state_d = StTrap;
                    default:   state_d = StWb;
                endcase
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == ClsStore);
                if (dmem_ready) begin
                    if (cls == ClsStore) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
                case (cls)
                    ClsLoad:         wb_sel = WbLoad;
                    ClsJal, ClsJalr: wb_sel = WbPc4;
                    ClsLui:          wb_sel = WbImmU;
                    default:         wb_sel = WbAlu;
                endcase
                if (cls == ClsJal) begin
                    pc_sel = PcBranch;
                end else if (cls == ClsJalr) begin
                    pc_sel = PcJalr;
                end
            end
            StTrap:  state_d = StTrap;
            default: state_d = StReset;
        endcase
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StReset;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign halt    = (state_q == StTrap);
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: walks each instruction class cycle by cycle.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch_taken, imem_ready, dmem_ready;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic [1:0]  pc_sel, wb_sel, alu_op;
    logic        alu_a_sel, alu_b_sel, retire, halt, illegal;
    logic [2:0]  imm_sel, state;
    logic [31:0] instret;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic [2:0] imm_sel;
        logic [1:0] alu_op;
        logic [2:0] state;
        logic       retire;
        logic       halt;
        logic       illegal;
    } ctrl_t;

    ctrl_t       obs, e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instret = 0;

    assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
                  alu_a_sel, alu_b_sel, imm_sel, alu_op, state, retire, halt, illegal};

    multicycle_ctrl #(.CNT_W(32), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .imm_sel      (imm_sel),
        .alu_op       (alu_op),
        .state        (state),
        .retire       (retire),
        .instret      (instret),
        .halt         (halt),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Stimulus only: completes a one-cycle fetch of instr; returns in DECODE.
    task automatic fetch_word(input logic [31:0] instr);
        opcode     = instr[6:0];
        funct3     = instr[14:12];
        imem_ready = 1'b1;
        #1;
        tick();
        imem_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        e = '0;
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_outputs got %h exp %h", obs, e); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
        rst = 1'b0;
        #1;
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_state got %h exp %h", obs, e); end
        tick();
        e = '0; e.state = 3'd1; e.imem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs !== e) begin errors++; $display("FAIL fetch_wait%0d got %h exp %h", i, obs, e); end
            tick();
        end
    endtask

    task automatic test_addi();
        opcode = 7'h13; funct3 = 3'd0; imem_ready = 1'b1;
        #1;
        e = '0; e.state = 3'd1; e.imem_req = 1'b1; e.ir_we = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL addi_fetch got %h exp %h", obs, e); end
        tick(); imem_ready = 1'b0; #1;
        e = '0; e.state = 3'd2;
        checks++; if (obs !== e) begin errors++; $display("FAIL addi_decode got %h exp %h", obs, e); end
        tick();
        e = '0; e.state = 3'd3; e.alu_op = 2'd1; e.alu_b_sel = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL addi_exec got %h exp %h", obs, e); end
        tick();
        e = '0; e.state = 3'd5; e.alu_op = 2'd1; e.alu_b_sel = 1'b1;
        e.rf_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL addi_wb got %h exp %h", obs, e); end
        tick();
        exp_instret++;
        e = '0; e.state = 3'd1; e.imem_req = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL addi_refetch got %h exp %h", obs, e); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL addi_instret got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_load();
        fetch_word(32'h0000A103);
        tick();
        e = '0; e.state = 3'd3; e.alu_b_sel = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL lw_exec got %h exp %h", obs, e); end
        tick();
        dmem_ready = 1'b0;
        e = '0; e.state = 3'd4; e.alu_b_sel = 1'b1; e.dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (obs !== e) begin errors++; $display("FAIL lw_mem_wait%0d got %h exp %h", i, obs, e); end
            tick();
        end
        dmem_ready = 1'b1; #1;
        checks++; if (obs !== e) begin errors++; $display("FAIL lw_mem_accept got %h exp %h", obs, e); end
        tick(); dmem_ready = 1'b0; #1;
        e = '0; e.state = 3'd5; e.alu_b_sel = 1'b1; e.wb_sel = 2'd1;
        e.rf_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL lw_wb got %h exp %h", obs, e); end
        tick();
        exp_instret++;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL lw_refetch got %0d exp 1", state); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL lw_instret got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_store();
        fetch_word(32'h0020A023);
        tick();
        e = '0; e.state = 3'd3; e.alu_b_sel = 1'b1; e.imm_sel = 3'd1;
        checks++; if (obs !== e) begin errors++; $display("FAIL sw_exec got %h exp %h", obs, e); end
        tick();
        dmem_ready = 1'b1; #1;
        e = '0; e.state = 3'd4; e.alu_b_sel = 1'b1; e.imm_sel = 3'd1;
        e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL sw_mem got %h exp %h", obs, e); end
        tick(); dmem_ready = 1'b0; #1;
        exp_instret++;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL sw_refetch got %0d exp 1", state); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL sw_instret got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            fetch_word(32'h00000463);
            tick();
            branch_taken = t[0]; #1;
            e = '0; e.state = 3'd3; e.alu_op = 2'd2; e.imm_sel = 3'd2;
            e.pc_we = 1'b1; e.pc_sel = {1'b0, t[0]}; e.retire = 1'b1;
            checks++; if (obs !== e) begin errors++; $display("FAIL beq_exec_taken%0d got %h exp %h", t, obs, e); end
            tick(); branch_taken = 1'b0;
            exp_instret++;
            checks++; if (state !== 3'd1) begin errors++; $display("FAIL beq_refetch%0d got %0d exp 1", t, state); end
        end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL beq_instret got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_jump_upper();
        logic [31:0] instrs [4] = '{32'h0080006F, 32'h000080E7, 32'h12345037, 32'h00001097};
        logic [2:0]  imm [4]    = '{3'd4, 3'd0, 3'd3, 3'd3};
        logic [1:0]  wbs [4]    = '{2'd2, 2'd2, 2'd3, 2'd0};
        logic [1:0]  pcs [4]    = '{2'd1, 2'd2, 2'd0, 2'd0};
        for (int i = 0; i < 4; i++) begin
            fetch_word(instrs[i]);
            tick();
            e = '0; e.state = 3'd3; e.imm_sel = imm[i];
            e.alu_a_sel = (i == 3); e.alu_b_sel = (i == 3);
            checks++; if (obs !== e) begin errors++; $display("FAIL jmp_exec%0d got %h exp %h", i, obs, e); end
            tick();
            e.state = 3'd5; e.rf_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
            e.wb_sel = wbs[i]; e.pc_sel = pcs[i];
            checks++; if (obs !== e) begin errors++; $display("FAIL jmp_wb%0d got %h exp %h", i, obs, e); end
            tick();
            exp_instret++;
        end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL jmp_instret got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_fence();
        fetch_word(32'h0FF0000F);
        tick();
        e = '0; e.state = 3'd3; e.pc_we = 1'b1; e.retire = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL fence_exec got %h exp %h", obs, e); end
        tick();
        exp_instret++;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL fence_instret got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_illegal();
        fetch_word(32'h00000000);
        e = '0; e.state = 3'd2;
        checks++; if (obs !== e) begin errors++; $display("FAIL ill_decode got %h exp %h", obs, e); end
        imem_ready = 1'b1; dmem_ready = 1'b1;
        tick();
        e = '0; e.state = 3'd6; e.halt = 1'b1; e.illegal = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++; if (obs !== e) begin errors++; $display("FAIL ill_trap%0d got %h exp %h", i, obs, e); end
            tick();
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL ill_instret got %0d exp %0d", instret, exp_instret); end
    endtask

    task automatic test_reset_mid_mem();
        rst = 1'b1; #1; rst = 1'b0;
        exp_instret = 0;
        tick();
        fetch_word(32'h0000A103);
        tick(); tick();
        e = '0; e.state = 3'd4; e.alu_b_sel = 1'b1; e.dmem_req = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL rstmem_pre got %h exp %h", obs, e); end
        rst = 1'b1; #1;
        e = '0;
        checks++; if (obs !== e) begin errors++; $display("FAIL rstmem_drop got %h exp %h", obs, e); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL rstmem_instret got %0d exp 0", instret); end
        tick();
        rst = 1'b0; #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rstmem_sreset got %0d exp 0", state); end
        tick();
        e = '0; e.state = 3'd1; e.imem_req = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL rstmem_fetch got %h exp %h", obs, e); end
    endtask

    task automatic test_system();
        fetch_word(32'h00000073);
        tick();
        e = '0; e.state = 3'd3;
        checks++; if (obs !== e) begin errors++; $display("FAIL ecall_exec got %h exp %h", obs, e); end
        tick();
        e = '0; e.state = 3'd6; e.halt = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL ecall_trap got %h exp %h", obs, e); end
        rst = 1'b1; #1; rst = 1'b0;
        tick();
    endtask

    task automatic test_bad_branch();
        fetch_word(32'h00002063);
        tick();
        e = '0; e.state = 3'd3; e.alu_op = 2'd2; e.imm_sel = 3'd2;
        checks++; if (obs !== e) begin errors++; $display("FAIL badbr_exec got %h exp %h", obs, e); end
        tick();
        e = '0; e.state = 3'd6; e.halt = 1'b1; e.illegal = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL badbr_trap got %h exp %h", obs, e); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL badbr_instret got %0d exp 0", instret); end
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0;
        branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        test_reset();
        test_addi();
        test_load();
        test_store();
        test_branch();
        test_jump_upper();
        test_fence();
        test_illegal();
        test_reset_mid_mem();
        test_system();
        test_bad_branch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
